// File: rtl/addressing_unit.sv
// Program counter and effective-address generator for the 16-bit datapath.
// Define ADDR_IMM_SIGN_EXT_EN to sign-extend the PC-relative immediate (zero-extended otherwise).
module addressing_unit (
    input  logic [15:0] Rside,
    input  logic [7:0]  Iside,
    output logic [15:0] Address,
    input  logic        clk,
    input  logic        ResetPC,
    input  logic        PCplusI,
    input  logic        PCplus1,
    input  logic        Iplus0,
    input  logic        Rplus0,
    input  logic        PCenable
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned EXT_W  = ADDR_W - IMM_W;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] rel_offset;
    logic [ADDR_W-1:0] imm_zext;
    logic [ADDR_W-1:0] pc_rel;
    logic [ADDR_W-1:0] pc_inc;

    // Branch offset extension is a build-time choice; Iplus0 always zero-extends.
`ifdef ADDR_IMM_SIGN_EXT_EN
    assign rel_offset = {{EXT_W{Iside[IMM_W-1]}}, Iside};
`else
    assign rel_offset = {{EXT_W{1'b0}}, Iside};
`endif

    assign imm_zext = {{EXT_W{1'b0}}, Iside};
    assign pc_rel   = ADDR_W'(pc_q + rel_offset);
    assign pc_inc   = ADDR_W'(pc_q + ADDR_W'(1));

    // Priority mux written as a ternary chain so unknown selects propagate X.
    assign Address = ResetPC ? '0       :
                     PCplusI ? pc_rel   :
                     PCplus1 ? pc_inc   :
                     Iplus0  ? imm_zext :
                     Rplus0  ? Rside    :
                               pc_q;

    always_comb begin
        pc_d = pc_q;
        if (PCenable) begin
            pc_d = Address;
        end
    end

    always_ff @(posedge clk) begin
        if (ResetPC) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_addressing_unit.sv
// Scoreboard bench for addressing_unit: stimulus queues expected addresses, a negedge monitor checks them.
module tb_addressing_unit;

    logic        clk;
    logic        ResetPC;
    logic [15:0] Rside;
    logic [7:0]  Iside;
    logic [15:0] Address;
    logic        PCplusI;
    logic        PCplus1;
    logic        Iplus0;
    logic        Rplus0;
    logic        PCenable;

    logic [15:0] exp_q [$];
    string       name_q [$];
    int          checks;
    int          errors;

    addressing_unit dut (
        .Rside    (Rside),
        .Iside    (Iside),
        .Address  (Address),
        .clk      (clk),
        .ResetPC  (ResetPC),
        .PCplusI  (PCplusI),
        .PCplus1  (PCplus1),
        .Iplus0   (Iplus0),
        .Rplus0   (Rplus0),
        .PCenable (PCenable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected Address per stimulus cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (Address !== e) begin
                errors++;
                $display("FAIL %s: Address=%h expected=%h", n, Address, e);
            end
        end
    end

    // Drive one cycle of inputs and queue the Address they should produce.
    task automatic apply(input logic rst, input logic pci, input logic pc1,
                         input logic ip0, input logic rp0, input logic en,
                         input logic [15:0] r, input logic [7:0] i,
                         input logic [15:0] exp_addr, input string nm);
        @(posedge clk);
        #1;
        ResetPC  = rst;
        PCplusI  = pci;
        PCplus1  = pc1;
        Iplus0   = ip0;
        Rplus0   = rp0;
        PCenable = en;
        Rside    = r;
        Iside    = i;
        exp_q.push_back(exp_addr);
        name_q.push_back(nm);
    endtask

    initial begin
        logic [15:0] exp_rel_neg;
        logic [15:0] exp_rel_fe;
        checks   = 0;
        errors   = 0;
        ResetPC  = 1'b0;
        PCplusI  = 1'b0;
        PCplus1  = 1'b0;
        Iplus0   = 1'b0;
        Rplus0   = 1'b0;
        PCenable = 1'b0;
        Rside    = 16'h0000;
        Iside    = 8'h00;
`ifdef ADDR_IMM_SIGN_EXT_EN
        exp_rel_fe  = 16'h00FE;
        exp_rel_neg = 16'hFFF5;
`else
        exp_rel_fe  = 16'h01FE;
        exp_rel_neg = 16'h00F5;
`endif

        //     rst pci pc1 ip0 rp0 en   Rside     Iside  expected
        apply(1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, "reset_during");
        apply(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, "reset_after");
        apply(0, 0, 0, 1, 0, 1, 16'h000E, 8'h0D, 16'h000D, "iplus0_addr");
        apply(0, 0, 0, 0, 0, 0, 16'h000E, 8'h0D, 16'h000D, "iplus0_pc");
        apply(0, 0, 0, 0, 1, 0, 16'h000E, 8'h0D, 16'h000E, "rplus0_addr");
        apply(0, 0, 0, 0, 0, 0, 16'h000E, 8'h0D, 16'h000D, "rplus0_hold_pc");

        apply(0, 0, 0, 0, 1, 1, 16'h0005, 8'h00, 16'h0005, "load_5");
        apply(0, 0, 1, 0, 0, 1, 16'h0000, 8'h00, 16'h0006, "incr_1");
        apply(0, 0, 1, 0, 0, 1, 16'h0000, 8'h00, 16'h0007, "incr_2");
        apply(0, 0, 1, 0, 0, 1, 16'h0000, 8'h00, 16'h0008, "incr_3");
        apply(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0008, "incr_pc");

        apply(0, 0, 0, 0, 1, 1, 16'hFFFF, 8'h00, 16'hFFFF, "load_ffff");
        apply(0, 0, 1, 0, 0, 1, 16'h0000, 8'h00, 16'h0000, "wrap_addr");
        apply(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, "wrap_pc");

        apply(0, 0, 0, 0, 1, 1, 16'h0100, 8'h00, 16'h0100, "load_0100");
        apply(0, 1, 0, 0, 0, 0, 16'h0000, 8'hFE, exp_rel_fe, "rel_fe");
        apply(0, 0, 0, 0, 0, 0, 16'h0000, 8'hFE, 16'h0100, "rel_no_load");

        apply(0, 0, 1, 0, 1, 0, 16'h1234, 8'h00, 16'h0101, "prio_pc1_over_r");
        apply(0, 1, 1, 0, 0, 0, 16'h1234, 8'h02, 16'h0102, "prio_pci_over_pc1");
        apply(0, 0, 0, 1, 1, 0, 16'h1234, 8'h80, 16'h0080, "prio_i_zext");

        apply(0, 0, 0, 0, 1, 1, 16'h0005, 8'h00, 16'h0005, "load_0005");
        apply(0, 1, 0, 0, 0, 1, 16'h0000, 8'hF0, exp_rel_neg, "rel_f0_addr");
        apply(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, exp_rel_neg, "rel_f0_pc");

        apply(1, 0, 0, 0, 1, 1, 16'hABCD, 8'h00, 16'h0000, "reset_with_en");
        apply(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, "reset_wins_pc");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addressing_unit.md
# addressing_unit

Program-counter and effective-address generator for the 16-bit processor datapath. It holds the program counter (PC) and forms a 16-bit memory address from one of four sources: the PC, the PC plus an 8-bit immediate offset, the PC plus 1, or a register/immediate operand. The address is presented combinationally to memory. The PC optionally captures that address on the clock edge. It sits between the controller's address-select strobes and the memory address bus.

## Interface
Parameters: none.
- `clk` input 1: system clock; all state changes on the rising edge.
- `ResetPC` input 1: one clock; reset is synchronous and active-high. It clears the PC and also forces `Address` to 0.
- `Rside` input 16: register-file operand (base address source).
- `Iside` input 8: immediate operand from the instruction word.
- `Address` output 16: effective address, combinational.
- `PCplusI` input 1: select PC + offset(`Iside`).
- `PCplus1` input 1: select PC + 1.
- `Iplus0` input 1: select zero-extended `Iside`.
- `Rplus0` input 1: select `Rside`.
- `PCenable` input 1: PC load enable; PC captures `Address` on the rising edge.
- Positional port order: `Rside, Iside, Address, clk, ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, PCenable`.

## Operation
- Internal state: 16-bit register `PC`.
- `Address` select, in fixed priority order (the first asserted source wins):
  - `ResetPC` gives 16'h0000.
  - `PCplusI` gives PC + ext(`Iside`), modulo 2^16. The extension is set by the configuration macro below.
  - `PCplus1` gives PC + 1, modulo 2^16.
  - `Iplus0` gives {8'h00, `Iside`}.
  - `Rplus0` gives `Rside`.
  - No select asserted gives PC (hold / fetch current PC).
- Multiple selects asserted: the priority above applies. No error is flagged.
- PC update at the rising edge of `clk`:
  - If `ResetPC` = 1: PC <= 0, regardless of `PCenable`.
  - Else if `PCenable` = 1: PC <= `Address`.
  - Else: PC holds.
- Arithmetic is 16-bit with no carry out: 16'hFFFF + 1 wraps to 16'h0000, and PC + negative offset wraps below 0.
- Any X/Z on a select input yields X on `Address`. The PC is not protected from X loads.

## Timing
- `Address` is purely combinational from PC, the select inputs, `Rside` and `Iside`: zero-cycle latency.
- The PC update has 1-cycle latency: the value of `Address` sampled at edge N becomes the PC after edge N, and is visible on `Address` (with no select asserted) in that same cycle.
- Reset value: PC = 16'h0000. With `ResetPC` asserted, `Address` = 0 immediately. After release with no selects asserted, `Address` = 0.
- Reset in the middle of a sequence discards any pending load: reset wins over `PCenable` at the same edge.
- There is no handshake. Selects and `PCenable` are level-sampled at each rising edge.

## Configuration
- Macro: `ADDR_IMM_SIGN_EXT_EN`.
  - Defined: `PCplusI` sign-extends `Iside` (relative branch range −128..+127).
  - Undefined: `PCplusI` zero-extends `Iside` (range 0..255).
- `Iplus0` always zero-extends, with or without the macro.

## Test plan
- Reset: assert `ResetPC` for 1 edge with `PCenable` = 0. Required: PC = 0, and `Address` = 16'h0000 both during and after reset (no selects asserted).
- Register/immediate paths with PC = 0:
  - `Rside` = 16'h000E, `Iside` = 8'h0D, `PCenable` = 1, `Iplus0` = 1 → `Address` = 16'h000D; PC = 16'h000D after the edge.
  - Then `Rplus0` only → `Address` = 16'h000E.
- Increment and wrap:
  - PC = 16'h0005, `PCplus1` = 1, `PCenable` = 1, 3 edges → PC = 16'h0008.
  - PC = 16'hFFFF with `PCplus1` → PC = 16'h0000.
- Relative offset: PC = 16'h0100, `Iside` = 8'hFE, `PCplusI` = 1.
  - With macro defined → `Address` = 16'h00FE.
  - Without macro → `Address` = 16'h01FE.
- Priority and hold:
  - `PCplus1` and `Rplus0` both asserted → the PC + 1 result is selected.
  - `PCenable` = 0 with `Rplus0` = 1 → `Address` = `Rside` and the PC is unchanged.
  - `ResetPC` together with `PCenable` = 1 → PC = 0.
